// File: rtl/mem_bus_router.sv
// mem_bus_router: routes PicoRV32 native memory requests to NSLV
// memory-mapped slaves through registered request and response stages.
// Unmapped addresses and slaves that never answer produce an error completion.
module mem_bus_router #(
    parameter int unsigned          NSLV        = 4,
    parameter logic [NSLV*32-1:0]   ADDR_BASE   = '0,
    parameter logic [NSLV*32-1:0]   ADDR_MASK   = '0,
    parameter logic [15:0]          TIMEOUT_CYC = 16'd1024,
    parameter logic [31:0]          ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 core_valid_i,
    input  logic [31:0]          core_addr_i,
    input  logic [31:0]          core_wdata_i,
    input  logic [3:0]           core_wstrb_i,
    output logic [31:0]          core_rdata_o,
    output logic                 core_ready_o,
    output logic [NSLV-1:0]      slv_valid_o,
    output logic [31:0]          slv_addr_o,
    output logic [31:0]          slv_wdata_o,
    output logic [3:0]           slv_wstrb_o,
    input  logic [NSLV*32-1:0]   slv_rdata_i,
    input  logic [NSLV-1:0]      slv_ready_i,
    output logic                 err_o,
    output logic [31:0]          err_addr_o,
    output logic [15:0]          err_cnt_o
);

    localparam int unsigned IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  sel_idx;
    logic [15:0]       tmo_cnt;

    logic              dec_hit_c;
    logic [IDX_W-1:0]  dec_idx_c;
    logic              sel_ready_c;
    logic [31:0]       sel_rdata_c;
    logic              timeout_c;

    // Address decode; scanning downwards lets the lowest matching index win.
    always_comb begin
        dec_hit_c = 1'b0;
        dec_idx_c = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((core_addr_i & ADDR_MASK[i*32 +: 32]) ==
                (ADDR_BASE[i*32 +: 32] & ADDR_MASK[i*32 +: 32])) begin
                dec_hit_c = 1'b1;
                dec_idx_c = IDX_W'(i);
            end
        end
    end

    // Response mux for the latched slave; other slaves' ready is ignored.
    always_comb begin
        sel_ready_c = 1'b0;
        sel_rdata_c = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_ready_c = slv_ready_i[i];
                sel_rdata_c = slv_rdata_i[i*32 +: 32];
            end
        end
    end

    // Expires at the end of the TIMEOUT_CYC-th ACCESS cycle; zero disables it.
    always_comb begin
        timeout_c = (TIMEOUT_CYC != 16'd0) && (tmo_cnt == (TIMEOUT_CYC - 16'd1));
    end

    // Request/response FSM with registered bus and error outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            sel_idx      <= '0;
            tmo_cnt      <= '0;
            slv_valid_o  <= '0;
            slv_addr_o   <= '0;
            slv_wdata_o  <= '0;
            slv_wstrb_o  <= '0;
            core_ready_o <= 1'b0;
            core_rdata_o <= '0;
            err_o        <= 1'b0;
            err_addr_o   <= '0;
            err_cnt_o    <= '0;
        end else begin
            core_ready_o <= 1'b0;
            err_o        <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (core_valid_i) begin
                        slv_addr_o  <= core_addr_i;
                        slv_wdata_o <= core_wdata_i;
                        slv_wstrb_o <= core_wstrb_i;
                        sel_idx     <= dec_idx_c;
                        tmo_cnt     <= '0;
                        if (dec_hit_c) begin
                            slv_valid_o <= NSLV'(1) << dec_idx_c;
                            state       <= ST_ACCESS;
                        end else begin
                            core_ready_o <= 1'b1;
                            core_rdata_o <= ERR_RDATA;
                            err_o        <= 1'b1;
                            err_addr_o   <= core_addr_i;
                            if (err_cnt_o != 16'hFFFF) begin
                                err_cnt_o <= err_cnt_o + 16'd1;
                            end
                            state <= ST_DONE;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (sel_ready_c) begin
                        slv_valid_o  <= '0;
                        core_ready_o <= 1'b1;
                        core_rdata_o <= sel_rdata_c;
                        state        <= ST_DONE;
                    end else if (timeout_c) begin
                        slv_valid_o  <= '0;
                        core_ready_o <= 1'b1;
                        core_rdata_o <= ERR_RDATA;
                        err_o        <= 1'b1;
                        err_addr_o   <= slv_addr_o;
                        if (err_cnt_o != 16'hFFFF) begin
                            err_cnt_o <= err_cnt_o + 16'd1;
                        end
                        state <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    slv_valid_o <= '0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_router.sv
// Directed bench for mem_bus_router with a response scoreboard.
module tb_mem_bus_router;

    localparam int unsigned NSLV     = 4;
    localparam logic [15:0] TMO      = 16'd8;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 core_valid;
    logic [31:0]          core_addr;
    logic [31:0]          core_wdata;
    logic [3:0]           core_wstrb;
    logic [31:0]          core_rdata;
    logic                 core_ready;
    logic [NSLV-1:0]      slv_valid;
    logic [31:0]          slv_addr;
    logic [31:0]          slv_wdata;
    logic [3:0]           slv_wstrb;
    logic [NSLV*32-1:0]   slv_rdata;
    logic [NSLV-1:0]      slv_ready;
    logic                 err;
    logic [31:0]          err_addr;
    logic [15:0]          err_cnt;

    typedef struct {
        logic [31:0] rdata;
        bit          chk_rdata;
        bit          err;
        int          lat;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_cnt = 16'd0;

    mem_bus_router #(
        .NSLV        (NSLV),
        .ADDR_BASE   ({32'h0400_0000, 32'h0300_0000, 32'h0200_0000, 32'h0000_0000}),
        .ADDR_MASK   ({4{32'hFF00_0000}}),
        .TIMEOUT_CYC (TMO),
        .ERR_RDATA   (ERR_DATA)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .core_valid_i (core_valid),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_wstrb_i (core_wstrb),
        .core_rdata_o (core_rdata),
        .core_ready_o (core_ready),
        .slv_valid_o  (slv_valid),
        .slv_addr_o   (slv_addr),
        .slv_wdata_o  (slv_wdata),
        .slv_wstrb_o  (slv_wstrb),
        .slv_rdata_i  (slv_rdata),
        .slv_ready_i  (slv_ready),
        .err_o        (err),
        .err_addr_o   (err_addr),
        .err_cnt_o    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every output must sit at its reset value.
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_slv_valid"},  32'(slv_valid), 32'h0);
        chk({tag, "_slv_addr"},   slv_addr, 32'h0);
        chk({tag, "_slv_wdata"},  slv_wdata, 32'h0);
        chk({tag, "_slv_wstrb"},  32'(slv_wstrb), 32'h0);
        chk({tag, "_core_ready"}, 32'(core_ready), 32'h0);
        chk({tag, "_core_rdata"}, core_rdata, 32'h0);
        chk({tag, "_err"},        32'(err), 32'h0);
        chk({tag, "_err_addr"},   err_addr, 32'h0);
        chk({tag, "_err_cnt"},    32'(err_cnt), 32'h0);
    endtask

    // One core transaction; slave < 0 means no slave is expected to be selected,
    // rdy_cyc is the cycle (1 = first ACCESS cycle) the slave raises ready, 0 = never.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int slave, input int rdy_cyc,
                           input logic [31:0] sdata, input bit exp_err, input bit chk_data);
        exp_t            e;
        exp_t            got;
        int              last_v;
        int              c;
        bit              done;
        logic [NSLV-1:0] ev;
        logic [NSLV-1:0] onehot;
        onehot      = (slave >= 0) ? (NSLV'(1) << slave) : '0;
        e.err       = exp_err;
        e.addr      = addr;
        e.chk_rdata = chk_data || exp_err;
        e.rdata     = exp_err ? ERR_DATA : sdata;
        if (slave < 0)                                 e.lat = 1;
        else if (rdy_cyc > 0 && rdy_cyc <= int'(TMO))  e.lat = rdy_cyc + 1;
        else                                           e.lat = int'(TMO) + 1;
        last_v = e.lat - 1;
        if (exp_err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        sb.push_back(e);

        @(negedge clk);
        core_valid = 1'b1;
        core_addr  = addr;
        core_wdata = wdata;
        core_wstrb = wstrb;
        if (slave >= 0) slv_rdata[slave*32 +: 32] = sdata;
        c    = 0;
        done = 1'b0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            ev = (slave >= 0 && c <= last_v) ? onehot : '0;
            chk({tag, "_slv_valid"}, 32'(slv_valid), 32'(ev));
            if (c == 1 && slave >= 0) begin
                chk({tag, "_slv_addr"},  slv_addr, addr);
                chk({tag, "_slv_wdata"}, slv_wdata, wdata);
                chk({tag, "_slv_wstrb"}, 32'(slv_wstrb), 32'(wstrb));
            end
            if (core_ready) begin
                if (sb.size() == 0) begin
                    chk({tag, "_unexpected_ready"}, 32'(core_ready), 32'h0);
                end else begin
                    got = sb.pop_front();
                    chk({tag, "_latency"}, 32'(c), 32'(got.lat));
                    if (got.chk_rdata) chk({tag, "_rdata"}, core_rdata, got.rdata);
                    chk({tag, "_err"}, 32'(err), 32'(got.err));
                    if (got.err) chk({tag, "_err_addr"}, err_addr, got.addr);
                    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
                end
                core_valid = 1'b0;
                done       = 1'b1;
            end
            slv_ready = (slave >= 0 && c == rdy_cyc) ? onehot : '0;
        end
        if (!done) begin
            chk({tag, "_no_completion"}, 32'(done), 32'h1);
            sb.delete();
            core_valid = 1'b0;
        end
        slv_ready = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        core_valid = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        core_wstrb = '0;
        slv_rdata  = '0;
        slv_ready  = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Minimum-latency read from slave 2.
        run_txn("rd_s2", 32'h0300_0010, 32'h0, 4'h0, 2, 1, 32'h1234_5678, 1'b0, 1'b1);
        // Write to slave 0 with ready in cycle 3.
        run_txn("wr_s0", 32'h0000_0004, 32'hA5A5_A5A5, 4'h3, 0, 3, 32'h0, 1'b0, 1'b0);
        // Unmapped read.
        run_txn("unmap_rd", 32'h0800_0000, 32'h0, 4'h0, -1, 0, 32'h0, 1'b1, 1'b1);
        // Slave 3 never answers.
        run_txn("tmo_s3", 32'h0400_0000, 32'h0, 4'h0, 3, 0, 32'h0, 1'b1, 1'b1);

        // Late ready from slave 3 must not produce anything.
        slv_ready = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rdy_core_ready", 32'(core_ready), 32'h0);
            chk("late_rdy_slv_valid", 32'(slv_valid), 32'h0);
            chk("late_rdy_err", 32'(err), 32'h0);
        end
        slv_ready = '0;

        // Ready in the timeout-expiry cycle wins.
        run_txn("rdy_at_tmo", 32'h0200_0100, 32'h0, 4'h0, 1, int'(TMO), 32'hCAFE_0001, 1'b0, 1'b1);
        // Unmapped write still returns the error data.
        run_txn("unmap_wr", 32'h1000_0000, 32'h1111_2222, 4'hF, -1, 0, 32'h0, 1'b1, 1'b1);
        // Back-to-back reads on different slaves.
        run_txn("b2b_s1", 32'h0200_0040, 32'h0, 4'h0, 1, 2, 32'h0BAD_F00D, 1'b0, 1'b1);
        run_txn("b2b_s3", 32'h04FF_FFFC, 32'h0, 4'h0, 3, 1, 32'h7654_3210, 1'b0, 1'b1);

        // Run of unmapped accesses, then push the counter into saturation.
        for (int i = 0; i < 50; i++) begin
            run_txn("unmap_loop", 32'h0500_0000 + 32'(i), 32'h0, 4'h0, -1, 0, 32'h0, 1'b1, 1'b1);
        end
        @(negedge clk);
        force dut.err_cnt_o = 16'hFFFC;
        @(negedge clk);
        release dut.err_cnt_o;
        exp_cnt = 16'hFFFC;
        for (int i = 0; i < 6; i++) begin
            run_txn("sat", 32'hF000_0000, 32'h0, 4'h0, -1, 0, 32'h0, 1'b1, 1'b1);
        end

        // Reset in the middle of an access to slave 2.
        @(negedge clk);
        core_valid = 1'b1;
        core_addr  = 32'h0300_0020;
        core_wdata = 32'h0;
        core_wstrb = 4'h0;
        repeat (3) @(negedge clk);
        chk("mid_rst_pre_valid", 32'(slv_valid), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        core_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_ready", 32'(core_ready), 32'h0);
        end
        rst_n   = 1'b1;
        exp_cnt = 16'd0;
        @(negedge clk);
        chk("post_rst_no_ready", 32'(core_ready), 32'h0);
        run_txn("post_rst_rd", 32'h0300_0020, 32'h0, 4'h0, 2, 2, 32'h5A5A_0F0F, 1'b0, 1'b1);
        run_txn("post_rst_unmap", 32'h0900_0000, 32'h0, 4'h0, -1, 0, 32'h0, 1'b1, 1'b1);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_router.md
# mem_bus_router

Parametrised request router between the PicoRV32 native memory port and NSLV memory-mapped targets: RAM, native IP, APB bridge, PSRAM and future additions. It is the configurable successor to the fixed four-way core-side split. Slave windows are set by base/mask parameters. Each access passes through a registered request stage and a registered response stage. Unmapped addresses and unresponsive slaves get a defined error response, so the core never hangs.

## Interface
- NSLV, 4: number of slave ports (1..16).
- ADDR_BASE, {NSLV{32'h0}}: packed base addresses; slave i at [i*32+:32].
- ADDR_MASK, {NSLV{32'h0}}: packed masks; slave i hits when (addr & mask_i) == (base_i & mask_i).
- TIMEOUT_CYC, 1024: slave-wait limit in cycles (16-bit); 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on any error response.
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- core_valid_i  in  1  master request; held until core_ready_o is sampled.
- core_addr_i  in  32  byte address.
- core_wdata_i  in  32  write data.
- core_wstrb_i  in  4  byte strobes; 0 means read.
- core_rdata_o  out  32  read data, valid while core_ready_o=1.
- core_ready_o  out  1  one-cycle completion pulse.
- slv_valid_o  out  NSLV  per-slave request, one-hot or zero.
- slv_addr_o  out  32  registered address, shared by all slaves.
- slv_wdata_o  out  32  registered write data, shared.
- slv_wstrb_o  out  4  registered strobes, shared.
- slv_rdata_i  in  NSLV*32  packed slave read data.
- slv_ready_i  in  NSLV  per-slave completion.
- err_o  out  1  one-cycle pulse on any error completion.
- err_addr_o  out  32  address of the most recent error.
- err_cnt_o  out  16  saturating error count.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - On core_valid_i=1, decode the address. The lowest-index matching slave wins.
  - Register addr/wdata/wstrb into slv_*_o and latch the slave index.
  - Hit -> ACCESS. No hit -> DONE with an error flag set.
- **ACCESS**
  - slv_valid_o[idx]=1. The timeout counter increments every cycle.
  - slv_ready_i[idx]=1 -> capture slv_rdata_i[idx], clear slv_valid_o, go to DONE.
  - Counter reaches TIMEOUT_CYC without ready -> clear slv_valid_o, set the error flag, go to DONE.
  - Ready and timeout expiring in the same cycle: ready wins, no error.
- **DONE**
  - core_ready_o=1 for exactly one cycle.
  - core_rdata_o is the captured data, or ERR_RDATA on error.
  - On error: err_o=1, err_addr_o is updated, err_cnt_o increments (saturates at 16'hFFFF).
  - core_valid_i is ignored in DONE; the core is still holding the finished request. Next state is IDLE.
- Writes follow the same path. Read data is don't-care for writes, but ERR_RDATA is still driven on a write error.
- slv_ready_i on a non-selected slave, or arriving after a timeout, is ignored.
- Decode uses only the parameters; no runtime remap.

## Timing
- Reset values:
  - State IDLE, counter 0, error flag 0.
  - slv_valid_o 0; slv_addr_o, slv_wdata_o, slv_wstrb_o 0.
  - core_ready_o 0, core_rdata_o 0.
  - err_o 0, err_addr_o 0, err_cnt_o 0.
- Latency, with the request sampled at edge 0:
  - slv_valid_o is high from cycle 1.
  - Slave ready in cycle k gives core_ready_o in cycle k+1. Minimum is 2 cycles (ready in cycle 1).
- Unmapped access: core_ready_o with ERR_RDATA in cycle 1.
- Timeout: slv_valid_o is high for exactly TIMEOUT_CYC cycles, then core_ready_o follows in the next cycle.
- Back-to-back: a new request can be accepted in the first IDLE cycle after DONE.
- Reset asserted mid-access: all outputs return to reset values asynchronously. No response is issued for the aborted access.

## Test plan
Bench parameters: NSLV=4, bases 0x0000_0000 / 0x0200_0000 / 0x0300_0000 / 0x0400_0000, all masks 0xFF00_0000, TIMEOUT_CYC=8.
- Read 0x0300_0010; slave 2 returns 0x1234_5678 with ready in cycle 1 -> only slv_valid_o[2] rises; core_ready_o in cycle 2 with 0x1234_5678; err_o stays 0.
- Write 0x0000_0004, wdata 0xA5A5_A5A5, wstrb 0x3; slave 0 ready after 3 cycles -> slv_wstrb_o=0x3, slv_wdata_o=0xA5A5_A5A5; core_ready_o exactly one cycle after slave ready.
- Read 0x0800_0000 (unmapped) -> no slv_valid_o; core_ready_o in cycle 1 with 0xDEAD_BEEF; err_o pulse; err_addr_o=0x0800_0000; err_cnt_o=1.
- Read 0x0400_0000 with slave 3 never ready -> slv_valid_o[3] high 8 cycles, then core_ready_o with 0xDEAD_BEEF and err_o. A late slv_ready_i[3] has no effect.
- Ready arriving in the timeout-expiry cycle -> normal data returned, err_cnt_o unchanged. Then 70000 unmapped accesses -> err_cnt_o saturates at 0xFFFF.
- Reset asserted during ACCESS -> slv_valid_o and all other outputs clear immediately; no core_ready_o; the next request after reset completes normally.
